// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse front end: enables reporting (0xF4/0xFA), decodes 3-byte packets into a clamped cursor.
// Optional ack timeout / 0xFE retry with init_err reporting is built when MOUSE_RETRY_EN is defined.
module ps2_mouse_cursor #(
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int SHIFT       = 0,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tx_done,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic [2:0]    buttons,
  output logic          click,
  output logic          packet_valid,
  output logic          ready,
  output logic          init_err
);

  localparam int MW = (XW > YW) ? XW : YW;
  localparam int W  = ((MW > 9) ? MW : 9) + 2;
  localparam logic signed [W-1:0] XMAX_W = W'(X_MAX);
  localparam logic signed [W-1:0] YMAX_W = W'(Y_MAX);

  typedef enum logic [2:0] {SEND, WAIT_TX, WAIT_ACK, B1, B2, B3, UPDATE, FAIL} state_t;

  state_t state_q, state_d;
  logic [7:0] b1_q, b2_q, b3_q;
  logic tx_start_d, ld_b1, ld_b2, ld_b3, do_update, ack_ok;
  logic signed [8:0] dx9, dy9, dx_sh, dy_sh;
  logic signed [W-1:0] x_sum, y_sum;
  logic [XW-1:0] x_clamp;
  logic [YW-1:0] y_clamp;

  assign tx_data = 8'hF4;

`ifdef MOUSE_RETRY_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic [1:0]    retry_q;
  logic          attempt_fail;
`endif

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    ld_b1      = 1'b0;
    ld_b2      = 1'b0;
    ld_b3      = 1'b0;
    do_update  = 1'b0;
    ack_ok     = 1'b0;
`ifdef MOUSE_RETRY_EN
    attempt_fail = 1'b0;
`endif
    case (state_q)
      SEND: begin
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: if (tx_done) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (rx_valid && rx_data == 8'hFA) begin
          ack_ok  = 1'b1;
          state_d = B1;
        end
`ifdef MOUSE_RETRY_EN
        else if ((rx_valid && rx_data == 8'hFE) || cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          attempt_fail = 1'b1;
          state_d      = (retry_q == 2'd3) ? FAIL : SEND;
        end
`endif
      end
      // bit3 is always set in a header byte; anything else is dropped to resynchronise
      B1: if (rx_valid && rx_data[3]) begin
        ld_b1   = 1'b1;
        state_d = B2;
      end
      B2: if (rx_valid) begin
        ld_b2   = 1'b1;
        state_d = B3;
      end
      B3: if (rx_valid) begin
        ld_b3   = 1'b1;
        state_d = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        state_d   = B1;
        if (rx_valid && rx_data[3]) begin
          ld_b1   = 1'b1;
          state_d = B2;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = SEND;
    endcase
  end

  always_comb begin
    dx9   = b1_q[6] ? 9'sd0 : $signed({b1_q[4], b2_q});
    dy9   = b1_q[7] ? 9'sd0 : $signed({b1_q[5], b3_q});
    dx_sh = dx9 >>> SHIFT;
    dy_sh = dy9 >>> SHIFT;
    // PS/2 +Y points up while screen Y grows downward
    x_sum = $signed({{(W-XW){1'b0}}, cursor_x}) + $signed({{(W-9){dx_sh[8]}}, dx_sh});
    y_sum = $signed({{(W-YW){1'b0}}, cursor_y}) - $signed({{(W-9){dy_sh[8]}}, dy_sh});
    if (x_sum[W-1])          x_clamp = '0;
    else if (x_sum > XMAX_W) x_clamp = XW'(X_MAX);
    else                     x_clamp = x_sum[XW-1:0];
    if (y_sum[W-1])          y_clamp = '0;
    else if (y_sum > YMAX_W) y_clamp = YW'(Y_MAX);
    else                     y_clamp = y_sum[YW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SEND;
      tx_start     <= 1'b0;
      b1_q         <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
      cursor_x     <= XW'(X_INIT);
      cursor_y     <= YW'(Y_INIT);
      buttons      <= '0;
      click        <= 1'b0;
      packet_valid <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_start     <= tx_start_d;
      click        <= 1'b0;
      packet_valid <= 1'b0;
      if (ld_b1)  b1_q  <= rx_data;
      if (ld_b2)  b2_q  <= rx_data;
      if (ld_b3)  b3_q  <= rx_data;
      if (ack_ok) ready <= 1'b1;
      if (do_update) begin
        cursor_x     <= x_clamp;
        cursor_y     <= y_clamp;
        buttons      <= b1_q[2:0];
        click        <= b1_q[0] & ~buttons[0];
        packet_valid <= 1'b1;
      end
    end
  end

`ifdef MOUSE_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      retry_q  <= '0;
      init_err <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT_ACK && state_d == WAIT_ACK) ? cnt_q + 1'b1 : '0;
      if (attempt_fail && retry_q != 2'd3) retry_q <= retry_q + 1'b1;
      if (state_d == FAIL) init_err <= 1'b1;
    end
  end
`else
  assign init_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor: enable handshake, packet decode, clamping, resync, retry.
module tb_ps2_mouse_cursor;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start, click, packet_valid, ready, init_err;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic [2:0] buttons;
  int errors = 0, checks = 0;

  ps2_mouse_cursor #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .buttons(buttons), .click(click), .packet_valid(packet_valid), .ready(ready),
    .init_err(init_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; step(); rx_valid = 1'b0;
  endtask

  // returns one cycle after byte 3 was sampled, when outputs hold the new values
  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c); step();
  endtask

  task automatic do_enable();
    reset = 1'b1; rx_valid = 1'b0; tx_done = 1'b0;
    step(); step(); reset = 1'b0;
    repeat (4) begin step(); tx_done = tx_start; end
    tx_done = 1'b0;
    send_byte(8'hFA);
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step();
    checks++; if (cursor_x !== 10'd320) begin errors++; $display("FAIL rst_x: got %0d expected 320", cursor_x); end
    checks++; if (cursor_y !== 9'd240) begin errors++; $display("FAIL rst_y: got %0d expected 240", cursor_y); end
    checks++; if (buttons !== 3'b000) begin errors++; $display("FAIL rst_buttons: got %b expected 000", buttons); end
    checks++; if ({click, packet_valid, ready, init_err, tx_start} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b expected 00000", {click, packet_valid, ready, init_err, tx_start}); end
    checks++; if (tx_data !== 8'hF4) begin errors++; $display("FAIL tx_data: got %h expected f4", tx_data); end
  endtask

  task automatic test_enable();
    int pulses;
    reset = 1'b0; pulses = 0;
    step();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL tx_start_first: got %b expected 1", tx_start); end
    if (tx_start) pulses++;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (3) begin if (tx_start) pulses++; step(); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b expected 0", ready); end
    send_byte(8'h55);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_nonack: got %b expected 0", ready); end
    send_byte(8'hFA);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_ack: got %b expected 1", ready); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL tx_pulses: got %0d expected 1", pulses); end
    checks++; if (cursor_x !== 10'd320 || cursor_y !== 9'd240) begin
      errors++; $display("FAIL enable_pos: got %0d,%0d expected 320,240", cursor_x, cursor_y); end
  endtask

  task automatic test_packet();
    send_byte(8'h08); send_byte(8'h05); send_byte(8'h03);
    checks++; if (packet_valid !== 1'b0 || cursor_x !== 10'd320) begin
      errors++; $display("FAIL pkt_early: got pv=%b x=%0d expected pv=0 x=320", packet_valid, cursor_x); end
    step();
    checks++; if (packet_valid !== 1'b1) begin errors++; $display("FAIL pkt_pv: got %b expected 1", packet_valid); end
    checks++; if (cursor_x !== 10'd325) begin errors++; $display("FAIL pkt_x: got %0d expected 325", cursor_x); end
    checks++; if (cursor_y !== 9'd237) begin errors++; $display("FAIL pkt_y: got %0d expected 237", cursor_y); end
    checks++; if (buttons !== 3'b000 || click !== 1'b0) begin
      errors++; $display("FAIL pkt_btn: got %b/%b expected 000/0", buttons, click); end
    step();
    checks++; if (packet_valid !== 1'b0) begin errors++; $display("FAIL pkt_pv_drop: got %b expected 0", packet_valid); end
  endtask

  task automatic test_click();
    pkt(8'h09, 8'h00, 8'h00);
    checks++; if (click !== 1'b1 || buttons !== 3'b001) begin
      errors++; $display("FAIL click_first: got %b/%b expected 1/001", click, buttons); end
    step();
    checks++; if (click !== 1'b0) begin errors++; $display("FAIL click_drop: got %b expected 0", click); end
    pkt(8'h09, 8'h00, 8'h00);
    checks++; if (click !== 1'b0 || buttons !== 3'b001 || packet_valid !== 1'b1) begin
      errors++; $display("FAIL click_held: got %b/%b/%b expected 0/001/1", click, buttons, packet_valid); end
    checks++; if (cursor_x !== 10'd325 || cursor_y !== 9'd237) begin
      errors++; $display("FAIL click_pos: got %0d,%0d expected 325,237", cursor_x, cursor_y); end
  endtask

  task automatic test_clamp();
    do_enable();
    pkt(8'h18, 8'h00, 8'h00);
    checks++; if (cursor_x !== 10'd64) begin errors++; $display("FAIL clamp_x64: got %0d expected 64", cursor_x); end
    pkt(8'h18, 8'h00, 8'h00);
    checks++; if (cursor_x !== 10'd0) begin errors++; $display("FAIL clamp_x0: got %0d expected 0", cursor_x); end
    repeat (5) pkt(8'h08, 8'h7F, 8'h00);
    checks++; if (cursor_x !== 10'd635) begin errors++; $display("FAIL clamp_x635: got %0d expected 635", cursor_x); end
    pkt(8'h08, 8'h7F, 8'h00);
    checks++; if (cursor_x !== 10'd639) begin errors++; $display("FAIL clamp_xmax: got %0d expected 639", cursor_x); end
    pkt(8'h28, 8'h00, 8'h80);
    checks++; if (cursor_y !== 9'd368) begin errors++; $display("FAIL clamp_y368: got %0d expected 368", cursor_y); end
    pkt(8'h28, 8'h00, 8'h80);
    checks++; if (cursor_y !== 9'd479) begin errors++; $display("FAIL clamp_ymax: got %0d expected 479", cursor_y); end
    repeat (4) pkt(8'h08, 8'h00, 8'h7F);
    checks++; if (cursor_y !== 9'd0) begin errors++; $display("FAIL clamp_y0: got %0d expected 0", cursor_y); end
  endtask

  task automatic test_resync();
    do_enable();
    send_byte(8'h00);
    pkt(8'h08, 8'h0A, 8'h00);
    checks++; if (cursor_x !== 10'd330 || packet_valid !== 1'b1) begin
      errors++; $display("FAIL resync_x: got x=%0d pv=%b expected 330/1", cursor_x, packet_valid); end
    pkt(8'h48, 8'h10, 8'h00);
    checks++; if (cursor_x !== 10'd330 || packet_valid !== 1'b1) begin
      errors++; $display("FAIL xovf: got x=%0d pv=%b expected 330/1", cursor_x, packet_valid); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h08); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h03); send_byte(8'h00);
    step();
    checks++; if (cursor_x !== 10'd335 || cursor_y !== 9'd240 || packet_valid !== 1'b1) begin
      errors++; $display("FAIL b2b: got %0d,%0d pv=%b expected 335,240 pv=1", cursor_x, cursor_y, packet_valid); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h08); send_byte(8'h05);
    reset = 1'b1; #1;
    checks++; if (cursor_x !== 10'd320 || ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got x=%0d ready=%b expected 320/0", cursor_x, ready); end
    do_enable();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready); end
    pkt(8'h08, 8'h01, 8'h00);
    checks++; if (cursor_x !== 10'd321) begin errors++; $display("FAIL mid_pkt: got %0d expected 321", cursor_x); end
  endtask

  task automatic test_retry();
`ifdef MOUSE_RETRY_EN
    int pulses;
    reset = 1'b1; step(); step(); reset = 1'b0; pulses = 0;
    for (int i = 0; i < 2000 && !init_err; i++) begin
      step(); tx_done = tx_start; if (tx_start) pulses++;
    end
    tx_done = 1'b0;
    checks++; if (init_err !== 1'b1) begin errors++; $display("FAIL retry_err: got %b expected 1", init_err); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL retry_pulses: got %0d expected 4", pulses); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL retry_ready: got %b expected 0", ready); end
    repeat (300) begin step(); tx_done = tx_start; if (tx_start) pulses++; end
    tx_done = 1'b0;
    checks++; if (pulses !== 4 || init_err !== 1'b1) begin
      errors++; $display("FAIL retry_hold: got pulses=%0d err=%b expected 4/1", pulses, init_err); end
`else
    repeat (200) step();
    checks++; if (init_err !== 1'b0) begin errors++; $display("FAIL no_retry_err: got %b expected 0", init_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_enable();
    test_packet();
    test_click();
    test_clamp();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    test_retry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_cursor.md
# ps2_mouse_cursor

Parametrised PS/2 mouse front end that sits between the byte-level PS/2 PHY (receiver/transmitter) and the game logic. After reset it enables data reporting on the mouse (command 0xF4, waits for ack 0xFA), then decodes 3-byte movement packets into an absolute, clamped on-screen cursor position, the button state and a left-click pulse. It replaces the fixed-size mouse controller with configurable screen bounds, start position, sensitivity and optional command retry.

## Interface
- X_MAX, 639: largest legal cursor_x (inclusive).
- Y_MAX, 479: largest legal cursor_y (inclusive).
- XW, 10: width of cursor_x; must satisfy 2^XW > X_MAX.
- YW, 9: width of cursor_y; must satisfy 2^YW > Y_MAX.
- X_INIT, 320: cursor_x after reset.
- Y_INIT, 240: cursor_y after reset.
- SHIFT, 0: sensitivity; movement deltas are arithmetic-shifted right by SHIFT (0..3).
- TIMEOUT_CYC, 2500000: ack timeout in clk cycles (used only with MOUSE_RETRY_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_data  in  8  byte from PS/2 receiver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_done  in  1  one-cycle strobe, transmitter finished a byte.
- tx_data  out  8  byte to transmit; constant 0xF4.
- tx_start  out  1  one-cycle request to transmit tx_data.
- cursor_x  out  XW  absolute X, 0 = left.
- cursor_y  out  YW  absolute Y, 0 = top.
- buttons  out  3  {middle, right, left}, 1 = pressed.
- click  out  1  one-cycle pulse on left-button press.
- packet_valid  out  1  one-cycle pulse, outputs just updated.
- ready  out  1  high once the mouse acknowledged enable.
- init_err  out  1  sticky, enable failed (MOUSE_RETRY_EN only; else tied 0).

## Operation
- States: SEND, WAIT_TX, WAIT_ACK, B1, B2, B3, UPDATE (plus FAIL with MOUSE_RETRY_EN).
- SEND: assert tx_start one cycle -> WAIT_TX.
- WAIT_TX: wait tx_done -> WAIT_ACK; rx_valid ignored.
- WAIT_ACK: rx_valid with 0xFA -> B1, ready=1; any other byte ignored.
- B1: rx_valid with bit3=1 -> latch byte, B2; bit3=0 -> discard, stay B1 (resynchronisation).
- B2: rx_valid -> latch dx byte, B3. B3: rx_valid -> latch dy byte, UPDATE.
- UPDATE (one cycle): register outputs, pulse packet_valid -> B1. An rx_valid in this cycle is evaluated as a B1 candidate.
- dx = 9-bit two's complement {b1[4], b2}; dy = {b1[5], b3}. If b1[6] (X overflow) dx := 0; if b1[7] dy := 0.
- Apply `>>> SHIFT` (arithmetic) to dx and dy.
- x_new = cursor_x + dx; y_new = cursor_y - dy (PS/2 +Y is up); computed signed in max(XW,YW)+2 bits, clamped to [0, X_MAX] / [0, Y_MAX].
- buttons <= b1[2:0]; click = 1 in the UPDATE result cycle iff b1[0]=1 and previous buttons[0]=0.

## Timing
- Reset values: cursor_x=X_INIT, cursor_y=Y_INIT, buttons=0, click=0, packet_valid=0, ready=0, init_err=0, tx_start=0, state SEND.
- tx_start asserted the first cycle after reset release.
- Latency: rx_valid of byte 3 sampled at edge N; cursor_x/y, buttons, click, packet_valid take new values after edge N+1; click/packet_valid drop after edge N+2.
- Reset mid-packet: partial packet discarded; re-enable sequence restarts.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MOUSE_RETRY_EN defined: WAIT_ACK counts cycles; at TIMEOUT_CYC or on rx byte 0xFE, re-enter SEND. After 3 failed retries (4 attempts) -> FAIL: init_err=1, ready=0, held until reset.
- Not defined: no timeout counter, 0xFE ignored, WAIT_ACK waits forever, init_err constant 0.

## Test plan
- Reset, tx_done after tx_start, send 0xFA -> ready=1, cursor=(320,240), exactly one tx_start pulse.
- Packet 0x08,0x05,0x03 -> cursor=(325,237), buttons=0, packet_valid one cycle at N+1.
- Packet 0x09,0x00,0x00 twice -> click pulses once (first packet only), buttons=3'b001.
- From (320,240) send 0x18,0x00,0x00 (dx=-256) twice -> x=64 then x=0 (clamped); 0x08,0x7F,0x00 x6 -> x=639.
- Stray 0x00 then 0x08,0x0A,0x00 -> first byte discarded, x increases by 10; packet 0x48,0x10,0x00 (X overflow) -> x unchanged.
- MOUSE_RETRY_EN, TIMEOUT_CYC=100, never ack -> 4 tx_start pulses, then init_err=1, ready=0.
